score_group: RTL and testbench

SCORE_GROUP -- requirements
Module: score_group

---
 rtl/corner_detector_pkg.sv | 16 +
 rtl/tag_delay.sv | 34 +++
 rtl/score_group.sv | 92 +++++++++
 tb/tb_score_group.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/corner_detector_pkg.sv
// Shared corner detector parameters: score width, group size, group index width, max stage latency.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package corner_detector_pkg;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned GROUP_L = 16;
  localparam int unsigned GRP_W   = 8;
  localparam int unsigned MAX_LAT = GROUP_L - 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tag_delay.sv
// Fixed-depth shift line for a small tag (valid + index), cleared by reset.
// Latency: DEPTH cycles from d to q; DEPTH=0 is a wire.
// Backpressure: none, accepts a new entry every cycle.
module tag_delay #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 15
) (
  input  logic             c,
  input  logic             r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift one stage per cycle; reset empties every stage.
      always_ff @(posedge c) begin
        if (r) begin
          for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/score_group.sv
// Collects L corner scores into a packed group and presents it to the max stage with a group index.
// Latency: out_stb 1 cycle after the last sample's edge; q_valid/q_grp LAT cycles after out_stb.
// Backpressure: none; downstream must take every out_stb, input accepted on every in_valid.
module score_group
  import corner_detector_pkg::*;
#(
  parameter int unsigned W   = SCORE_W,
  parameter int unsigned L   = GROUP_L,
  parameter int unsigned G   = GRP_W,
  parameter int unsigned LAT = MAX_LAT
) (
  input  logic           c,
  input  logic           r,
  input  logic           in_valid,
  input  logic [W-1:0]   in_score,
  input  logic           in_sof,
  output logic [L*W-1:0] out_d,
  output logic           out_stb,
  output logic [G-1:0]   out_grp,
  output logic           q_valid,
  output logic [G-1:0]   q_grp,
  output logic           drop
);

  localparam int unsigned   FW        = idx_width(L);
  localparam logic [FW-1:0] FILL_LAST = FW'(L - 1);

  logic [FW-1:0]  fill;
  logic [L*W-1:0] col;
  logic [G-1:0]   grp_cnt;

  logic [FW-1:0]  wr_idx;
  logic [L*W-1:0] col_nxt;
  logic           done;
  logic [G-1:0]   grp_cur;
  logic [G:0]     tag_q;

  // Slot/index for this sample: start of frame restarts at element 0 and group 0.
  always_comb begin
    wr_idx  = in_sof ? '0 : fill;
    grp_cur = in_sof ? '0 : grp_cnt;
    done    = (wr_idx == FILL_LAST);
    col_nxt = col;
    for (int k = 0; k < int'(L); k++) begin
      if (wr_idx == FW'(k)) col_nxt[k*W +: W] = in_score;
    end
  end

  // Collection, group hand-off and drop reporting; reset wins over any sample.
  always_ff @(posedge c) begin
    if (r) begin
      fill    <= '0;
      col     <= '0;
      grp_cnt <= '0;
      out_d   <= '0;
      out_stb <= 1'b0;
      out_grp <= '0;
      drop    <= 1'b0;
    end else begin
      out_stb <= 1'b0;
      drop    <= 1'b0;
      if (in_valid) begin
        col  <= col_nxt;
        drop <= in_sof && (fill != '0);
        if (done) begin
          out_d   <= col_nxt;
          out_stb <= 1'b1;
          out_grp <= grp_cur;
          grp_cnt <= grp_cur + 1'b1;
          fill    <= '0;
        end else begin
          fill    <= wr_idx + 1'b1;
          grp_cnt <= grp_cur;
        end
      end
    end
  end

  tag_delay #(
    .WIDTH(G + 1),
    .DEPTH(LAT)
  ) u_tag_delay (
    .c(c),
    .r(r),
    .d({out_stb, out_grp}),
    .q(tag_q)
  );

  assign q_valid = tag_q[G];
  assign q_grp   = tag_q[G-1:0];

endmodule

// File: tb/tb_score_group.sv
// Randomized scoreboard bench for score_group against a queue-based group model.
// Latency: checks out_stb/drop one cycle after the sampling edge, q_valid LAT cycles later.
// Backpressure: none exercised; every output event is checked when it appears.
module tb_score_group;
  import corner_detector_pkg::*;

  localparam int unsigned W   = SCORE_W;
  localparam int unsigned L   = GROUP_L;
  localparam int unsigned G   = GRP_W;
  localparam int unsigned LAT = MAX_LAT;

  logic           c;
  logic           r;
  logic           in_valid;
  logic [W-1:0]   in_score;
  logic           in_sof;
  logic [L*W-1:0] out_d;
  logic           out_stb;
  logic [G-1:0]   out_grp;
  logic           q_valid;
  logic [G-1:0]   q_grp;
  logic           drop;

  score_group #(.W(W), .L(L), .G(G), .LAT(LAT)) dut (
    .c(c), .r(r), .in_valid(in_valid), .in_score(in_score), .in_sof(in_sof),
    .out_d(out_d), .out_stb(out_stb), .out_grp(out_grp),
    .q_valid(q_valid), .q_grp(q_grp), .drop(drop)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  int cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [L*W-1:0] d;
    logic [G-1:0]   grp;
  } grp_exp_t;

  typedef struct {
    int           cyc;
    logic [G-1:0] grp;
    logic [W-1:0] mx;
  } q_exp_t;

  grp_exp_t     stb_q[$];
  q_exp_t       qv_q[$];
  int           drop_q[$];
  logic [W-1:0] part[$];
  int           grp_idx  = 0;
  int           zero_cyc = -1;
  int           total    = 0;
  int           bad      = 0;

  // Stand-in for the downstream max stage: LAT-deep pipeline of max(out_d).
  logic [W-1:0] mx_pipe [LAT];

  function automatic logic [W-1:0] max_of(input logic [L*W-1:0] v);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(L); i++) if (v[i*W +: W] > m) m = v[i*W +: W];
    return m;
  endfunction

  always @(posedge c) begin
    mx_pipe[0] <= max_of(out_d);
    for (int i = 1; i < int'(LAT); i++) mx_pipe[i] <= mx_pipe[i-1];
  end

  task automatic chk(input string nm, input bit ok, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle and advance the reference model for the edge that samples it.
  task automatic step(input bit rst, input bit vld, input bit sof, input logic [W-1:0] sc);
    int             e;
    logic [L*W-1:0] d;
    logic [W-1:0]   mx;
    @(posedge c);
    #1;
    r        = rst;
    in_valid = vld;
    in_sof   = sof;
    in_score = sc;
    e = cyc + 1;
    if (rst) begin
      part.delete();
      grp_idx  = 0;
      zero_cyc = e;
      while (qv_q.size() > 0 && qv_q[qv_q.size()-1].cyc >= e) void'(qv_q.pop_back());
    end else if (vld) begin
      if (sof) begin
        if (part.size() != 0) drop_q.push_back(e);
        part.delete();
        grp_idx = 0;
      end
      part.push_back(sc);
      if (part.size() == int'(L)) begin
        d  = '0;
        mx = '0;
        for (int i = 0; i < int'(L); i++) begin
          d[i*W +: W] = part[i];
          if (part[i] > mx) mx = part[i];
        end
        stb_q.push_back('{cyc: e, d: d, grp: G'(grp_idx)});
        qv_q.push_back('{cyc: e + int'(LAT), grp: G'(grp_idx), mx: mx});
        grp_idx = (grp_idx + 1) % (1 << G);
        part.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, W'($urandom_range(0, 255)));
  endtask

  // Monitor: every output event must match the head of its expectation queue at its cycle.
  always @(negedge c) begin
    if (cyc == zero_cyc)
      chk("reset_zero", (out_d == '0) && !out_stb && (out_grp == '0) && !drop && !q_valid && (q_grp == '0),
          {out_stb, drop, q_valid, out_grp, q_grp, out_d}, '0);

    if (stb_q.size() > 0 && stb_q[0].cyc == cyc) begin
      chk("group", (out_stb === 1'b1) && (out_d === stb_q[0].d) && (out_grp === stb_q[0].grp),
          {out_stb, out_grp, out_d}, {1'b1, stb_q[0].grp, stb_q[0].d});
      void'(stb_q.pop_front());
    end else if (out_stb) begin
      chk("unexpected_stb", 1'b0, {out_grp, out_d}, '0);
    end

    if (qv_q.size() > 0 && qv_q[0].cyc == cyc) begin
      chk("q_tag", (q_valid === 1'b1) && (q_grp === qv_q[0].grp) && (mx_pipe[LAT-1] === qv_q[0].mx),
          {q_valid, q_grp, mx_pipe[LAT-1]}, {1'b1, qv_q[0].grp, qv_q[0].mx});
      void'(qv_q.pop_front());
    end else if (q_valid) begin
      chk("unexpected_q_valid", 1'b0, q_grp, '0);
    end

    if (drop_q.size() > 0 && drop_q[0] == cyc) begin
      chk("drop", drop === 1'b1, drop, 1);
      void'(drop_q.pop_front());
    end else if (drop) begin
      chk("unexpected_drop", 1'b0, drop, 0);
    end
  end

  initial begin
    logic [W-1:0] v;
    r        = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_score = '0;

    repeat (3) step(1'b1, 1'b0, 1'b0, '0);

    // Ramp 0..15 back-to-back.
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b0, W'(k));
    idle(20);

    // Same ramp with a gap after every sample.
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 1'b0, W'(k));
      step(1'b0, 1'b0, 1'b0, W'($urandom_range(0, 255)));
    end
    idle(4);

    // Partial group abandoned by a new frame starting with 0xBE.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, W'($urandom_range(0, 255)));
    step(1'b0, 1'b1, 1'b1, 8'hBE);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 1'b0, W'($urandom_range(0, 8'hBD)));
    idle(4);

    // Peak 0xBE at element 5 must reach the max stage output with q_valid.
    for (int k = 0; k < 16; k++) begin
      v = (k == 5) ? 8'hBE : W'($urandom_range(0, 8'hBD));
      step(1'b0, 1'b1, 1'b0, v);
    end
    idle(20);

    // 300 consecutive groups from a fresh frame: index wraps past 255.
    for (int g = 0; g < 300; g++)
      for (int k = 0; k < 16; k++)
        step(1'b0, 1'b1, (g == 0 && k == 0), W'($urandom_range(0, 255)));
    idle(3);

    // Reset mid-group, with a valid sample offered during reset.
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b0, W'($urandom_range(0, 255)));
    step(1'b1, 1'b1, 1'b0, 8'h77);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b0, W'(8'h40 + k));
    idle(20);

    // Random traffic: gaps, occasional frame starts and resets.
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 400) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0, W'($urandom_range(0, 255)));

    idle(int'(LAT) + 5);

    chk("stb_queue_drained",  stb_q.size() == 0,  stb_q.size(),  0);
    chk("q_queue_drained",    qv_q.size() == 0,   qv_q.size(),   0);
    chk("drop_queue_drained", drop_q.size() == 0, drop_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
